// File: rtl/conv_layer_scheduler.sv
// Layer sequencer: walks filter groups and output tiles, issuing one-cycle
// weight-load / compute / writeback requests and waiting for each done pulse.
module conv_layer_scheduler #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int FG_W          = 12 - $clog2(SYSTOLIC_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [10:0]                    num_filter,
  input  logic [15:0]                    num_tile,
  output logic                           wgt_start,
  output logic                           wgt_load,
  input  logic                           wgt_done,
  output logic                           cmp_start,
  input  logic                           cmp_done,
  output logic                           wb_start,
  input  logic                           wb_done,
  output logic [FG_W-1:0]                filter_group,
  output logic [15:0]                    tile_idx,
  output logic [$clog2(SYSTOLIC_SIZE):0] active_filters,
  output logic                           busy,
  output logic                           layer_done
);

  localparam int LOG_S = $clog2(SYSTOLIC_SIZE);
  localparam int AF_W  = LOG_S + 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    WGT_REQ,
    WGT_WAIT,
    CMP_REQ,
    CMP_WAIT,
    WB_REQ,
    WB_WAIT,
    ADVANCE,
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [10:0]       nf_q, nf_d;
  logic [15:0]       nt_q, nt_d;
  logic [FG_W-1:0]   fg_q, fg_d;
  logic [15:0]       tile_q, tile_d;
  logic [AF_W-1:0]   af_q, af_d;
  logic              busy_q, busy_d;
  logic              wgt_start_q, wgt_start_d;
  logic              wgt_load_q, wgt_load_d;
  logic              cmp_start_q, cmp_start_d;
  logic              wb_start_q, wb_start_d;
  logic              layer_done_q, layer_done_d;

  // Number of filter groups, rounding a partial last group up.
  function automatic logic [FG_W-1:0] group_count(input logic [10:0] nf);
    logic [11:0] sum;
    sum = {1'b0, nf} + 12'(SYSTOLIC_SIZE - 1);
    return FG_W'(sum >> LOG_S);
  endfunction

  // Only the last group can be partial; every other group is full.
  function automatic logic [AF_W-1:0] group_filters(input logic [FG_W-1:0] fg,
                                                    input logic [10:0]     nf);
    logic [LOG_S-1:0] rem;
    rem = nf[LOG_S-1:0];
    if ((fg == group_count(nf) - FG_W'(1)) && (rem != '0)) begin
      return AF_W'(rem);
    end
    return AF_W'(SYSTOLIC_SIZE);
  endfunction

  always_comb begin
    state_d = state_q;
    nf_d    = nf_q;
    nt_d    = nt_q;
    fg_d    = fg_q;
    tile_d  = tile_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          nf_d    = num_filter;
          nt_d    = num_tile;
          fg_d    = '0;
          tile_d  = '0;
          state_d = INIT;
        end
      end
      INIT: begin
        if ((nf_q == '0) || (nt_q == '0)) state_d = FINISH;
        else                                state_d = WGT_REQ;
      end
      WGT_REQ:  state_d = WGT_WAIT;
      WGT_WAIT: if (wgt_done) state_d = CMP_REQ;
      CMP_REQ:  state_d = CMP_WAIT;
      CMP_WAIT: if (cmp_done) state_d = WB_REQ;
      WB_REQ:   state_d = WB_WAIT;
      WB_WAIT:  if (wb_done) state_d = ADVANCE;
      ADVANCE: begin
        if (tile_q != nt_q - 16'd1) begin
          tile_d  = tile_q + 16'd1;
          state_d = CMP_REQ;
        end else begin
          tile_d = '0;
          if (fg_q == group_count(nf_q) - FG_W'(1)) begin
            state_d = FINISH;
          end else begin
            fg_d    = fg_q + FG_W'(1);
            state_d = WGT_REQ;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so each pulse lines up
    // exactly with the cycle the FSM occupies its state.
    wgt_start_d  = (state_d == INIT) && (nf_d != '0) && (nt_d != '0);
    wgt_load_d   = (state_d == WGT_REQ);
    cmp_start_d  = (state_d == CMP_REQ);
    wb_start_d   = (state_d == WB_REQ);
    layer_done_d = (state_d == FINISH);
    busy_d       = (state_d != IDLE);
    af_d         = group_filters(fg_d, nf_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      nf_q         <= '0;
      nt_q         <= '0;
      fg_q         <= '0;
      tile_q       <= '0;
      af_q         <= AF_W'(SYSTOLIC_SIZE);
      busy_q       <= 1'b0;
      wgt_start_q  <= 1'b0;
      wgt_load_q   <= 1'b0;
      cmp_start_q  <= 1'b0;
      wb_start_q   <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nf_q         <= nf_d;
      nt_q         <= nt_d;
      fg_q         <= fg_d;
      tile_q       <= tile_d;
      af_q         <= af_d;
      busy_q       <= busy_d;
      wgt_start_q  <= wgt_start_d;
      wgt_load_q   <= wgt_load_d;
      cmp_start_q  <= cmp_start_d;
      wb_start_q   <= wb_start_d;
      layer_done_q <= layer_done_d;
    end
  end

  assign wgt_start      = wgt_start_q;
  assign wgt_load       = wgt_load_q;
  assign cmp_start      = cmp_start_q;
  assign wb_start       = wb_start_q;
  assign layer_done     = layer_done_q;
  assign busy           = busy_q;
  assign filter_group   = fg_q;
  assign tile_idx       = tile_q;
  assign active_filters = af_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: a scoreboard of expected request
// pulses (kind, group, tile, active filters) is matched against DUT output.
`timescale 1ns/1ps
module tb_conv_layer_scheduler;

  logic        clk, rst_n, start;
  logic [10:0] num_filter;
  logic [15:0] num_tile;
  logic        wgt_start, wgt_load, wgt_done;
  logic        cmp_start, cmp_done;
  logic        wb_start, wb_done;
  logic [7:0]  filter_group;
  logic [15:0] tile_idx;
  logic [4:0]  active_filters;
  logic        busy, layer_done;

  logic resp_wgt, resp_cmp, resp_wb;
  logic man_wgt, man_cmp, man_wb;
  logic resp_en;
  int   resp_dly;

  assign wgt_done = resp_wgt | man_wgt;
  assign cmp_done = resp_cmp | man_cmp;
  assign wb_done  = resp_wb  | man_wb;

  conv_layer_scheduler #(.SYSTOLIC_SIZE(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_filter     (num_filter),
    .num_tile       (num_tile),
    .wgt_start      (wgt_start),
    .wgt_load       (wgt_load),
    .wgt_done       (wgt_done),
    .cmp_start      (cmp_start),
    .cmp_done       (cmp_done),
    .wb_start       (wb_start),
    .wb_done        (wb_done),
    .filter_group   (filter_group),
    .tile_idx       (tile_idx),
    .active_filters (active_filters),
    .busy           (busy),
    .layer_done     (layer_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];
  int cnt[6];
  int first[6];
  int busy_first, busy_last, busy_n;
  int t0;
  string kname[6] = '{"none", "wgt_start", "wgt_load", "cmp_start", "wb_start", "layer_done"};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_ev(int k, int fg, int t, int af);
    return {3'(k), 8'(fg), 16'(t), 5'(af)};
  endfunction

  function automatic int af_model(int g, int nf);
    int ng;
    ng = (nf + 15) / 16;
    if ((g == ng - 1) && (nf % 16 != 0)) return nf % 16;
    return 16;
  endfunction

  task automatic push_ev(int k, int fg, int t, int af);
    sb.push_back(pack_ev(k, fg, t, af));
  endtask

  task automatic push_layer(int nf, int nt);
    int ng;
    ng = (nf + 15) / 16;
    if (nf == 0 || nt == 0) begin
      push_ev(5, 0, 0, af_model(0, nf));
    end else begin
      push_ev(1, 0, 0, af_model(0, nf));
      for (int g = 0; g < ng; g++) begin
        push_ev(2, g, 0, af_model(g, nf));
        for (int t = 0; t < nt; t++) begin
          push_ev(3, g, t, af_model(g, nf));
          push_ev(4, g, t, af_model(g, nf));
        end
      end
      push_ev(5, ng - 1, 0, af_model(ng - 1, nf));
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 6; k++) begin
      cnt[k]   = 0;
      first[k] = -1;
    end
    busy_first = -1;
    busy_last  = -1;
    busy_n     = 0;
  endtask

  task automatic observe(int k);
    logic [31:0] obs;
    cnt[k]++;
    if (first[k] < 0) first[k] = cyc;
    obs = pack_ev(k, filter_group, tile_idx, active_filters);
    if (sb.size() == 0) check($sformatf("unexpected_%s", kname[k]), obs, 32'h0);
    else                check($sformatf("event_%s", kname[k]), obs, sb.pop_front());
  endtask

  // Output monitor, sampling 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (wgt_start)  observe(1);
        if (wgt_load)   observe(2);
        if (cmp_start)  observe(3);
        if (wb_start)   observe(4);
        if (layer_done) observe(5);
        if (busy) begin
          if (busy_first < 0) busy_first = cyc;
          busy_last = cyc;
          busy_n++;
        end
      end
    end
  end

  // Done responder: answers each request resp_dly cycles later.
  initial begin
    int wc, cc, bc;
    wc = 0; cc = 0; bc = 0;
    resp_wgt = 1'b0; resp_cmp = 1'b0; resp_wb = 1'b0;
    forever begin
      @(negedge clk);
      resp_wgt = (wc == 1);
      resp_cmp = (cc == 1);
      resp_wb  = (bc == 1);
      if (wc > 0) wc--;
      if (cc > 0) cc--;
      if (bc > 0) bc--;
      if (resp_en && wgt_load)  wc = resp_dly;
      if (resp_en && cmp_start) cc = resp_dly;
      if (resp_en && wb_start)  bc = resp_dly;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic start_layer(int nf, int nt);
    @(negedge clk);
    start      = 1'b1;
    num_filter = 11'(nf);
    num_tile   = 16'(nt);
    t0         = cyc;
    @(negedge clk);
    start      = 1'b0;
    num_filter = 11'($urandom);
    num_tile   = 16'($urandom);
  endtask

  task automatic wait_done(int maxc);
    for (int i = 0; i < maxc && cnt[5] == 0; i++) @(negedge clk);
    check("layer_done_count", cnt[5], 1);
  endtask

  task automatic run_layer(int nf, int nt);
    push_layer(nf, nt);
    clear_stats();
    start_layer(nf, nt);
    wait_done(2000);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_filter = '0; num_tile = '0;
    man_wgt = 1'b0; man_cmp = 1'b0; man_wb = 1'b0;
    resp_en = 1'b0; resp_dly = 1;
    clear_stats();
    repeat (3) @(negedge clk);
    check("reset_outputs", {wgt_start, wgt_load, cmp_start, wb_start, layer_done, busy,
                            filter_group, tile_idx}, 0);
    check("reset_active_filters", active_filters, 16);
    rst_n = 1'b1;
    @(negedge clk);

    // Minimum latency: every done one cycle after its request.
    resp_en = 1'b1; resp_dly = 1;
    run_layer(16, 1);
    check("min_wgt_start_cyc", first[1] - t0, 1);
    check("min_wgt_load_cyc",  first[2] - t0, 2);
    check("min_cmp_start_cyc", first[3] - t0, 4);
    check("min_wb_start_cyc",  first[4] - t0, 6);
    check("min_layer_done_cyc", first[5] - t0, 9);
    check("min_busy_first", busy_first - t0, 1);
    check("min_busy_last",  busy_last - t0, 9);
    check("min_busy_cycles", busy_n, 9);
    @(negedge clk);
    check("min_busy_idle", busy, 0);

    // Full loop: two groups, two tiles, three-cycle downstream latency.
    resp_dly = 3;
    run_layer(32, 2);
    check("full_wgt_load_cnt", cnt[2], 2);
    check("full_cmp_cnt", cnt[3], 4);
    check("full_wb_cnt", cnt[4], 4);

    // Remainder group: last group holds 8 filters.
    resp_dly = 2;
    run_layer(40, 1);
    check("rem_wgt_load_cnt", cnt[2], 3);

    // Zero configurations finish straight from INIT.
    run_layer(0, 5);
    check("zero_nf_done_cyc", first[5] - t0, 2);
    check("zero_nf_req_cnt", cnt[1] + cnt[2] + cnt[3] + cnt[4], 0);
    run_layer(16, 0);
    check("zero_nt_done_cyc", first[5] - t0, 2);
    check("zero_nt_req_cnt", cnt[1] + cnt[2] + cnt[3] + cnt[4], 0);

    // Spurious dones and a mid-layer start, all driven by hand.
    resp_en = 1'b0;
    push_layer(16, 1);
    clear_stats();
    start_layer(16, 1);
    for (int i = 0; i < 20 && cnt[2] == 0; i++) @(negedge clk);
    man_wgt = 1'b1;
    @(negedge clk);
    man_wgt = 1'b0; man_cmp = 1'b1; man_wb = 1'b1;
    @(negedge clk);
    man_cmp = 1'b0; man_wb = 1'b0;
    start = 1'b1; num_filter = 11'd40; num_tile = 16'd3;
    @(negedge clk);
    start = 1'b0;
    check("spur_no_cmp", cnt[3], 0);
    check("spur_wgt_load_cnt", cnt[2], 1);
    check("spur_busy", busy, 1);
    @(negedge clk);
    resp_dly = 1; resp_en = 1'b1; man_wgt = 1'b1;
    @(negedge clk);
    man_wgt = 1'b0;
    wait_done(200);
    check("spur_cmp_cyc", first[3] - t0, 7);
    check("spur_done_cyc", first[5] - t0, 12);
    check("spur_cmp_cnt", cnt[3], 1);
    check("spur_sb_drained", sb.size(), 0);

    // Asynchronous reset during CMP_WAIT of group 1.
    resp_dly = 3;
    push_layer(32, 2);
    clear_stats();
    start_layer(32, 2);
    for (int i = 0; i < 200 && cnt[3] < 3; i++) @(negedge clk);
    @(negedge clk);
    check("pre_reset_group", filter_group, 1);
    rst_n = 1'b0; resp_en = 1'b0;
    #1;
    check("midrst_outputs", {wgt_start, wgt_load, cmp_start, wb_start, layer_done, busy,
                             filter_group, tile_idx}, 0);
    check("midrst_active_filters", active_filters, 16);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    resp_dly = 1; resp_en = 1'b1;
    run_layer(16, 1);
    check("post_rst_done_cyc", first[5] - t0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
